add_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit carry-lookahead adder datapath among NREQ requesters. Each requester presents an operand pair under a valid/ready handshake. One request is granted per cycle. The granted pair passes through the single adder, and the result is registered and returned, tagged with the requester index, under a valid/ready handshake. The block sits between the issue logic of the ALU clients and the shared adder instance.

---
 rtl/add_rr_arbiter.sv | 109 ++++++++++
 tb/tb_add_rr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/add_rr_arbiter.sv
// add_rr_arbiter: round-robin arbiter sharing one 32-bit carry-lookahead adder among NREQ requesters
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   req_valid[NREQ]   : per-requester request flag
//   req_ready[NREQ]   : one-hot grant this cycle (zero when no grant)
//   req_a, req_b      : packed operands, requester i at [32*i+31:32*i]
//   req_cin[NREQ]     : per-requester carry-in (only when ADD_RR_ARB_CIN_EN is defined)
//   resp_valid/ready  : response handshake
//   resp_id           : index of the requester owning the response
//   resp_sum, carry   : 33-bit result {resp_carry, resp_sum}
// Optional feature macro: ADD_RR_ARB_CIN_EN (adds req_cin; otherwise carry-in is 0).
module add_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
`ifdef ADD_RR_ARB_CIN_EN
    input  logic [NREQ-1:0]    req_cin,
`endif
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [31:0]        resp_sum,
    output logic               resp_carry
);
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_found;
    logic           free;
    logic           grant;
    logic [31:0]    op_a;
    logic [31:0]    op_b;
    logic           cin;
    logic [31:0]    g;
    logic [31:0]    p;
    logic [32:0]    c;
    int             j;

    assign free = !resp_valid || resp_ready;

    // Search starts just after the last grant and wraps, so ptr itself is searched last.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!gnt_found && req_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(j);
            end
        end
    end

    // Gated by rst so nothing is granted while reset is held.
    always_comb begin
        req_ready = '0;
        if (!rst && free && gnt_found) req_ready[gnt_idx] = 1'b1;
    end

    assign grant = |req_ready;
    assign op_a  = req_a[32*gnt_idx +: 32];
    assign op_b  = req_b[32*gnt_idx +: 32];
`ifdef ADD_RR_ARB_CIN_EN
    assign cin   = req_cin[gnt_idx];
`else
    assign cin   = 1'b0;
`endif

    assign g = op_a & op_b;
    assign p = op_a ^ op_b;

    // 4-bit lookahead groups; group carries chain between groups.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[4*i+1] = g[4*i] | (p[4*i] & c[4*i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & c[4*i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
            c[4*i+4] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                     | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i])
                     | (&p[4*i +: 4] & c[4*i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= IDW'(NREQ - 1);
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_sum   <= '0;
            resp_carry <= 1'b0;
        end else if (grant) begin
            ptr        <= gnt_idx;
            resp_valid <= 1'b1;
            resp_id    <= gnt_idx;
            resp_sum   <= p ^ c[31:0];
            resp_carry <= c[32];
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_add_rr_arbiter.sv
// tb_add_rr_arbiter: directed bench with a cycle-level behavioural model for add_rr_arbiter
module tb_add_rr_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    req_cin;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_sum;
    logic               resp_carry;

    int checks = 0;
    int failures = 0;

    add_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
`ifdef ADD_RR_ARB_CIN_EN
        .req_cin(req_cin),
`endif
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_carry(resp_carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the response register and last-grant pointer must hold.
    int          m_ptr = NREQ - 1;
    logic        m_valid = 1'b0;
    int          m_id = 0;
    logic [32:0] m_res = '0;
    int          mg;
    logic [NREQ-1:0] m_ready;

    function automatic int mgrant();
        if (rst || !(!m_valid || resp_ready)) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int jj = (m_ptr + k) % NREQ;
            if (req_valid[jj]) return jj;
        end
        return -1;
    endfunction

    function automatic logic [32:0] msum(input int i);
        logic [32:0] s;
        s = {1'b0, req_a[32*i +: 32]} + {1'b0, req_b[32*i +: 32]};
`ifdef ADD_RR_ARB_CIN_EN
        s = s + {32'd0, req_cin[i]};
`endif
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = NREQ - 1; m_valid = 1'b0; m_id = 0; m_res = '0;
        end else begin
            int gg;
            gg = mgrant();
            if (gg >= 0) begin
                m_valid = 1'b1; m_id = gg; m_res = msum(gg); m_ptr = gg;
            end else if (resp_ready) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            mg = mgrant();
            m_ready = '0;
            if (mg >= 0) m_ready[mg] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(m_ready));
            chk("resp_valid", 64'(resp_valid), 64'(m_valid));
            chk("resp_id", 64'(resp_id), 64'(m_id));
            chk("resp_sum", 64'(resp_sum), 64'(m_res[31:0]));
            chk("resp_carry", 64'(resp_carry), 64'(m_res[32]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    int order [6];
    logic [31:0] snap_sum;
    logic [IDW-1:0] snap_id;

    initial begin
        rst = 1'b1; req_valid = 4'b0001; req_a = '0; req_b = '0; req_cin = '0; resp_ready = 1'b1;
        #2;
        chk("ready_in_reset", 64'(req_ready), 64'h0);
        step(); step();
        chk("reset_valid", 64'(resp_valid), 64'h0);
        chk("reset_sum", 64'(resp_sum), 64'h0);
        req_valid = '0;
        rst = 1'b0;
        step();
        // Single requester with carry out.
        set_ops(0, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid = 4'b0001;
        #1 chk("single_grant", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        chk("single_valid", 64'(resp_valid), 64'h1);
        chk("single_id", 64'(resp_id), 64'h0);
        chk("single_sum", 64'(resp_sum), 64'h0);
        chk("single_carry", 64'(resp_carry), 64'h1);
        // Restart from reset so the rotation starts at requester 0.
        rst = 1'b1; step(); rst = 1'b0;
        set_ops(0, 32'hF000_0000, 32'h1000_0000);
        set_ops(1, 32'h1234_5678, 32'h1111_1111);
        set_ops(2, 32'h8000_0000, 32'h8000_0001);
        set_ops(3, 32'h0000_FFFF, 32'h0000_0001);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            order[k] = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) order[k] = i;
            step();
        end
        chk("rr_0", 64'(order[0]), 64'd0);
        chk("rr_1", 64'(order[1]), 64'd1);
        chk("rr_2", 64'(order[2]), 64'd2);
        chk("rr_3", 64'(order[3]), 64'd3);
        chk("rr_4", 64'(order[4]), 64'd0);
        chk("rr_5", 64'(order[5]), 64'd1);
        chk("rr_last_sum", 64'(resp_sum), 64'h2345_6789);
        // Backpressure: pending result for requester 1 must hold.
        resp_ready = 1'b0;
        snap_sum = resp_sum; snap_id = resp_id;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 64'(req_ready), 64'h0);
            chk("bp_sum", 64'(resp_sum), 64'(snap_sum));
            chk("bp_id", 64'(resp_id), 64'(snap_id));
            step();
        end
        resp_ready = 1'b1;
        #1 chk("release_grant", 64'(req_ready), 64'b0100);
        step();
        chk("release_valid", 64'(resp_valid), 64'h1);
        chk("release_id", 64'(resp_id), 64'd2);
        chk("release_sum", 64'(resp_sum), 64'h0000_0001);
        chk("release_carry", 64'(resp_carry), 64'h1);
        // Wrap-around from ptr=2 with requesters 1 and 3.
        req_valid = 4'b1010;
        #1 chk("wrap_first", 64'(req_ready), 64'b1000);
        step();
        req_valid = 4'b0010;
        #1 chk("wrap_second", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        resp_ready = 1'b0;
        step();
        // Asynchronous reset in the middle of a cycle.
        chk("pre_rst_valid", 64'(resp_valid), 64'h1);
        req_valid = 4'b1110;
        #1 rst = 1'b1;
        #1;
        chk("async_valid", 64'(resp_valid), 64'h0);
        chk("async_id", 64'(resp_id), 64'h0);
        chk("async_ready", 64'(req_ready), 64'h0);
        rst = 1'b0;
        resp_ready = 1'b1;
        #1 chk("post_rst_grant", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        chk("post_rst_id", 64'(resp_id), 64'd1);
`ifdef ADD_RR_ARB_CIN_EN
        set_ops(2, 32'h7FFF_FFFF, 32'h0);
        req_cin = 4'b0100;
        req_valid = 4'b0100;
        #1 chk("cin_grant", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        chk("cin_sum", 64'(resp_sum), 64'h8000_0000);
        chk("cin_carry", 64'(resp_carry), 64'h0);
`endif
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
